// File: rtl/interupt_priority_arbiter.sv
// interupt_priority_arbiter
// Latches rising edges on NUM_IRQ request lines, applies a software enable
// mask, and issues the highest-priority eligible request (lowest index) as a
// one-cycle pulse with its ISR vector. Only one interrupt is in service at a
// time. Nothing else is issued until return_from_isr is seen.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous active-low reset
//   irq              raw request lines, asynchronous to clk
//   en_we/en_wdata   enable-mask write strobe and data
//   cpu_ready        pipeline can accept a redirect this cycle
//   return_from_isr  pulse: the current ISR has finished
//   interupt_signal  registered one-cycle issue pulse
//   isr_addr         registered vector of the last issued IRQ
//   irq_id           registered index of the last issued IRQ
//   in_service       high while an interrupt is being serviced
//   pending          latched requests
//   enable           current enable mask
`timescale 1ns/1ps

module interupt_priority_arbiter #(
    parameter int unsigned NUM_IRQ    = 8,
    parameter int unsigned ID_W       = 3,
    parameter logic [31:0] VEC_BASE   = 32'h0000_0100,
    parameter logic [31:0] VEC_STRIDE = 32'd4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_IRQ-1:0] irq,
    input  logic               en_we,
    input  logic [NUM_IRQ-1:0] en_wdata,
    input  logic               cpu_ready,
    input  logic               return_from_isr,
    output logic               interupt_signal,
    output logic [31:0]        isr_addr,
    output logic [ID_W-1:0]    irq_id,
    output logic               in_service,
    output logic [NUM_IRQ-1:0] pending,
    output logic [NUM_IRQ-1:0] enable
);

    typedef enum logic {
        IDLE       = 1'b0,
        IN_SERVICE = 1'b1
    } state_t;

    state_t             state;
    logic [NUM_IRQ-1:0] s1;
    logic [NUM_IRQ-1:0] s2;
    logic [NUM_IRQ-1:0] prev;

    logic [NUM_IRQ-1:0] rise_c;
    logic [NUM_IRQ-1:0] elig_c;
    logic [ID_W-1:0]    win_id_c;
    logic               issue_c;
    logic [NUM_IRQ-1:0] clr_c;

    // Edge detect, eligibility and fixed-priority winner (lowest index wins)
    always_comb begin
        rise_c   = s2 & ~prev;
        elig_c   = pending & enable;
        win_id_c = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (elig_c[i]) begin
                win_id_c = ID_W'(i);
            end
        end
        issue_c = (state == IDLE) && (elig_c != '0) && cpu_ready;
        clr_c   = issue_c ? (NUM_IRQ'(1) << win_id_c) : '0;
    end

    assign in_service = (state == IN_SERVICE);

    // Synchronizers, pending/enable registers, issue FSM and outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1              <= '0;
            s2              <= '0;
            prev            <= '0;
            pending         <= '0;
            enable          <= '0;
            state           <= IDLE;
            interupt_signal <= 1'b0;
            irq_id          <= '0;
            isr_addr        <= '0;
        end else begin
            s1   <= irq;
            s2   <= s1;
            prev <= s2;

            // A new edge on the line being issued keeps its pending bit set
            pending <= (pending & ~clr_c) | rise_c;

            if (en_we) begin
                enable <= en_wdata;
            end

            interupt_signal <= issue_c;
            if (issue_c) begin
                irq_id   <= win_id_c;
                isr_addr <= VEC_BASE + (32'(win_id_c) * VEC_STRIDE);
            end

            case (state)
                IDLE: begin
                    if (issue_c) begin
                        state <= IN_SERVICE;
                    end
                end
                IN_SERVICE: begin
                    if (return_from_isr) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_interupt_priority_arbiter.sv
// Directed bench for interupt_priority_arbiter with hand-computed expectations.
`timescale 1ns/1ps

module tb_interupt_priority_arbiter;

    logic        clk;
    logic        reset;
    logic [7:0]  irq;
    logic        en_we;
    logic [7:0]  en_wdata;
    logic        cpu_ready;
    logic        return_from_isr;
    logic        interupt_signal;
    logic [31:0] isr_addr;
    logic [2:0]  irq_id;
    logic        in_service;
    logic [7:0]  pending;
    logic [7:0]  enable;

    int checks = 0;
    int errors = 0;

    interupt_priority_arbiter dut (
        .clk             (clk),
        .reset           (reset),
        .irq             (irq),
        .en_we           (en_we),
        .en_wdata        (en_wdata),
        .cpu_ready       (cpu_ready),
        .return_from_isr (return_from_isr),
        .interupt_signal (interupt_signal),
        .isr_addr        (isr_addr),
        .irq_id          (irq_id),
        .in_service      (in_service),
        .pending         (pending),
        .enable          (enable)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulse a set of lines for one cycle; returns after the edge that samples them
    task automatic pulse_irq(input logic [7:0] lines);
        irq = lines;
        tick();
        irq = '0;
    endtask

    task automatic write_enable(input logic [7:0] mask);
        en_we    = 1'b1;
        en_wdata = mask;
        tick();
        en_we    = 1'b0;
    endtask

    task automatic pulse_return();
        return_from_isr = 1'b1;
        tick();
        return_from_isr = 1'b0;
    endtask

    task automatic check_issue(input string tag, input logic [2:0] id, input logic [31:0] addr);
        check({tag, "_sig"}, 32'(interupt_signal), 32'd1);
        check({tag, "_id"}, 32'(irq_id), 32'(id));
        check({tag, "_addr"}, isr_addr, addr);
        check({tag, "_insvc"}, 32'(in_service), 32'd1);
    endtask

    initial begin
        reset           = 1'b0;
        irq             = '0;
        en_we           = 1'b0;
        en_wdata        = '0;
        cpu_ready       = 1'b1;
        return_from_isr = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_sig", 32'(interupt_signal), 32'd0);
        check("rst_addr", isr_addr, 32'd0);
        check("rst_id", 32'(irq_id), 32'd0);
        check("rst_insvc", 32'(in_service), 32'd0);
        check("rst_pend", 32'(pending), 32'd0);
        check("rst_en", 32'(enable), 32'd0);
        reset = 1'b1;
        tick();

        write_enable(8'hFF);
        check("en_ff", 32'(enable), 32'hFF);

        // Single request on line 5: issue three edges after sampling
        pulse_irq(8'h20);                     // edge k
        tick();                               // k+1
        check("l5_k1_pend", 32'(pending), 32'h00);
        tick();                               // k+2
        check("l5_k2_pend", 32'(pending), 32'h20);
        check("l5_k2_sig", 32'(interupt_signal), 32'd0);
        tick();                               // k+3
        check_issue("l5", 3'd5, 32'h114);
        check("l5_pend", 32'(pending), 32'h00);
        tick();
        check("l5_pulse_end", 32'(interupt_signal), 32'd0);
        check("l5_id_hold", 32'(irq_id), 32'd5);
        check("l5_addr_hold", isr_addr, 32'h114);
        pulse_return();
        check("l5_ret", 32'(in_service), 32'd0);

        // Lines 6 and 2 together: 2 first, 6 after return plus one idle cycle
        pulse_irq(8'h44);
        tick();
        tick();
        check("l62_pend", 32'(pending), 32'h44);
        tick();
        check_issue("l2", 3'd2, 32'h108);
        check("l2_pend", 32'(pending), 32'h40);
        tick();
        tick();
        check("l2_hold_sig", 32'(interupt_signal), 32'd0);
        check("l2_hold_pend", 32'(pending), 32'h40);
        pulse_return();                       // edge r
        check("l2_ret_insvc", 32'(in_service), 32'd0);
        check("l2_ret_sig", 32'(interupt_signal), 32'd0);
        tick();                               // r+1
        check_issue("l6", 3'd6, 32'h118);
        check("l6_pend", 32'(pending), 32'h00);
        tick();
        pulse_return();

        // Masked request latches; enabling it later issues it
        write_enable(8'h00);
        pulse_irq(8'h08);
        tick();
        tick();
        tick();
        tick();
        check("mask_sig", 32'(interupt_signal), 32'd0);
        check("mask_pend", 32'(pending), 32'h08);
        check("mask_insvc", 32'(in_service), 32'd0);
        write_enable(8'h08);                  // old mask still used on this edge
        check("mask_wr_sig", 32'(interupt_signal), 32'd0);
        check("mask_wr_en", 32'(enable), 32'h08);
        tick();
        check_issue("l3", 3'd3, 32'h10C);
        check("l3_pend", 32'(pending), 32'h00);
        tick();
        pulse_return();

        // New edge on line 1 while line 4 is in service
        write_enable(8'hFF);
        pulse_irq(8'h10);
        tick();
        tick();
        tick();
        check_issue("l4", 3'd4, 32'h110);
        pulse_irq(8'h02);
        tick();
        tick();
        check("l1_wait_pend", 32'(pending), 32'h02);
        tick();
        tick();
        check("l1_wait_sig", 32'(interupt_signal), 32'd0);
        check("l1_wait_id", 32'(irq_id), 32'd4);
        check("l1_wait_insvc", 32'(in_service), 32'd1);
        pulse_return();
        check("l4_ret", 32'(in_service), 32'd0);
        tick();
        check_issue("l1", 3'd1, 32'h104);
        tick();
        pulse_return();
        // Return while idle is ignored
        pulse_return();
        tick();
        check("idle_ret_insvc", 32'(in_service), 32'd0);
        check("idle_ret_sig", 32'(interupt_signal), 32'd0);
        check("idle_ret_pend", 32'(pending), 32'h00);

        // cpu_ready stall: line 0 overtakes stalled line 7
        cpu_ready = 1'b0;
        pulse_irq(8'h80);
        tick();
        tick();
        tick();
        check("stall7_sig", 32'(interupt_signal), 32'd0);
        check("stall7_pend", 32'(pending), 32'h80);
        pulse_irq(8'h01);
        tick();
        tick();
        tick();
        check("stall0_sig", 32'(interupt_signal), 32'd0);
        check("stall0_pend", 32'(pending), 32'h81);
        cpu_ready = 1'b1;
        tick();
        check_issue("l0", 3'd0, 32'h100);
        check("l0_pend", 32'(pending), 32'h80);
        tick();
        pulse_return();
        tick();
        check_issue("l7", 3'd7, 32'h11C);

        // Reset mid-service with pending 8'hA0
        pulse_irq(8'hA0);
        tick();
        tick();
        check("pre_rst_pend", 32'(pending), 32'hA0);
        check("pre_rst_insvc", 32'(in_service), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_pend", 32'(pending), 32'h00);
        check("mid_rst_insvc", 32'(in_service), 32'd0);
        check("mid_rst_en", 32'(enable), 32'h00);
        check("mid_rst_id", 32'(irq_id), 32'd0);
        check("mid_rst_addr", isr_addr, 32'd0);
        check("mid_rst_sig", 32'(interupt_signal), 32'd0);
        #3;
        reset = 1'b1;
        tick();
        write_enable(8'hFF);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("post_rst_sig", 32'(interupt_signal), 32'd0);
        end
        check("post_rst_pend", 32'(pending), 32'h00);
        check("post_rst_insvc", 32'(in_service), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
